// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - stream interface for the immediate encoder
interface imm_encoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [31:0]          in_imm;
    logic [2:0]           in_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_instr, in_imm, in_sel, out_ready,
        input  in_ready, out_valid, out_instr, out_err, err_count
    );

    modport slave (
        input  in_valid, in_instr, in_imm, in_sel, out_ready,
        output in_ready, out_valid, out_instr, out_err, err_count
    );
endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - packs an immediate into RV32 I/S/B/U/J fields, registered output with 1-entry skid
module imm_encoder #(
    parameter int ERR_CNT_W   = 8,
    parameter bit ZERO_ON_ERR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    imm_encoder_if.slave  bus
);
    localparam logic [2:0] SEL_I = 3'b000;
    localparam logic [2:0] SEL_S = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_U = 3'b011;
    localparam logic [2:0] SEL_J = 3'b100;

    logic [31:0]          imm;
    logic [31:0]          imm_f;
    logic [31:0]          enc_instr;
    logic                 enc_err;

    logic                 out_valid_r;
    logic [31:0]          out_instr_r;
    logic                 out_err_r;
    logic                 skid_valid;
    logic [31:0]          skid_instr;
    logic                 skid_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    logic                 accept;
    logic                 out_free;

    assign imm = bus.in_imm;

    always_comb begin
        enc_err   = 1'b0;
        imm_f     = imm;
        enc_instr = bus.in_instr;
        case (bus.in_sel)
            SEL_I, SEL_S: enc_err = (imm[31:11] != {21{imm[11]}});
            SEL_B:        enc_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            SEL_U:        enc_err = (imm[11:0] != 12'd0);
            SEL_J:        enc_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
            default:      enc_err = 1'b1;
        endcase

        if (enc_err && ZERO_ON_ERR)
            imm_f = 32'd0;

        // Illegal selects fall through to the default and leave the template untouched.
        case (bus.in_sel)
            SEL_I: enc_instr = {imm_f[11:0], bus.in_instr[19:0]};
            SEL_S: enc_instr = {imm_f[11:5], bus.in_instr[24:12], imm_f[4:0], bus.in_instr[6:0]};
            SEL_B: enc_instr = {imm_f[12], imm_f[10:5], bus.in_instr[24:12],
                                imm_f[4:1], imm_f[11], bus.in_instr[6:0]};
            SEL_U: enc_instr = {imm_f[31:12], bus.in_instr[11:0]};
            SEL_J: enc_instr = {imm_f[20], imm_f[10:1], imm_f[11], imm_f[19:12], bus.in_instr[11:0]};
            default: enc_instr = bus.in_instr;
        endcase
    end

    assign accept   = bus.in_valid && !skid_valid;
    assign out_free = !out_valid_r || bus.out_ready;

    // The skid only fills while the output is stalled, so it is always empty when accept is possible
    // on a cycle where the output register is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'd0;
            out_err_r   <= 1'b0;
            skid_valid  <= 1'b0;
            skid_instr  <= 32'd0;
            skid_err    <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    out_valid_r <= 1'b1;
                    out_instr_r <= skid_instr;
                    out_err_r   <= skid_err;
                    skid_valid  <= 1'b0;
                end else if (accept) begin
                    out_valid_r <= 1'b1;
                    out_instr_r <= enc_instr;
                    out_err_r   <= enc_err;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_instr <= enc_instr;
                skid_err   <= enc_err;
            end

            if (accept && enc_err && (err_cnt != {ERR_CNT_W{1'b1}}))
                err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_r;
    assign bus.out_err   = out_err_r;
    assign bus.err_count = err_cnt;
endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder
module tb_imm_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_encoder_if #(.ERR_CNT_W(8)) m_if ();
    imm_encoder_if #(.ERR_CNT_W(2)) s_if ();

    imm_encoder #(.ERR_CNT_W(8), .ZERO_ON_ERR(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    imm_encoder #(.ERR_CNT_W(2), .ZERO_ON_ERR(1'b1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_popped = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [32:0] exp_q[$];

    localparam int NV = 12;
    logic [31:0] v_instr [NV] = '{32'h00000013, 32'h00000063, 32'h0000006F, 32'h00000037,
                                  32'h00000063, 32'hDEADBEEF, 32'h00002023, 32'h00000013,
                                  32'h0000006F, 32'h00000037, 32'hFFFFFFFF, 32'h00000063};
    logic [31:0] v_imm   [NV] = '{32'hFFFFFFFF, 32'h00000008, 32'h00000800, 32'h12345000,
                                  32'h00000003, 32'h00000005, 32'hFFFFFFFC, 32'h00000800,
                                  32'h00100000, 32'h12345001, 32'h00000000, 32'hFFFFFFFE};
    logic [2:0]  v_sel   [NV] = '{3'd0, 3'd2, 3'd4, 3'd3, 3'd2, 3'd7, 3'd1, 3'd0,
                                  3'd4, 3'd3, 3'd0, 3'd2};
    logic [31:0] v_exp   [NV] = '{32'hFFF00013, 32'h00000463, 32'h0010006F, 32'h12345037,
                                  32'h00000063, 32'hDEADBEEF, 32'hFE002E23, 32'h00000013,
                                  32'h0000006F, 32'h00000037, 32'h000FFFFF, 32'hFE000FE3};
    logic        v_err   [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                  1'b1, 1'b1, 1'b0, 1'b0};

    // Output monitor: a transfer happens on the posedge after a negedge with valid & ready.
    always @(negedge clk) begin
        if (!rst && m_if.out_valid && m_if.out_ready) begin
            logic [32:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL out_unexpected: got instr=%08h err=%0b, none expected", m_if.out_instr, m_if.out_err);
            end else begin
                e = exp_q.pop_front();
                n_popped++;
                if ({m_if.out_err, m_if.out_instr} !== e) begin
                    n_errors++;
                    $display("FAIL out_data: got instr=%08h err=%0b, expected instr=%08h err=%0b",
                             m_if.out_instr, m_if.out_err, e[31:0], e[32]);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input int idx);
        logic rdy;
        int   n = 0;
        m_if.in_valid = 1'b1;
        m_if.in_instr = v_instr[idx];
        m_if.in_imm   = v_imm[idx];
        m_if.in_sel   = v_sel[idx];
        forever begin
            @(negedge clk);
            rdy = m_if.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 100) break;
        end
        m_if.in_valid = 1'b0;
        n_checks++;
        if (!rdy) begin
            n_errors++;
            $display("FAIL send_timeout: vector %0d never accepted", idx);
        end else begin
            exp_q.push_back({v_err[idx], v_exp[idx]});
            if (v_err[idx] && exp_cnt != 8'hFF) exp_cnt++;
            n_checks++;
            if (m_if.err_count !== exp_cnt) begin
                n_errors++;
                $display("FAIL err_count: got %0d, expected %0d", m_if.err_count, exp_cnt);
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d items still outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1 || m_if.err_count !== 8'd0 ||
            m_if.out_instr !== 32'd0 || m_if.out_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got valid=%0b ready=%0b cnt=%0d instr=%08h err=%0b, expected 0 1 0 0 0",
                     m_if.out_valid, m_if.in_ready, m_if.err_count, m_if.out_instr, m_if.out_err);
        end
    endtask

    task automatic test_encode();
        m_if.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            send(i);
            @(posedge clk);
            #1;
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        m_if.out_ready = 1'b0;
        fork
            begin
                send(0);
                send(1);
                send(2);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                n_checks++;
                if (m_if.in_ready !== 1'b0 || m_if.out_valid !== 1'b1 || m_if.out_instr !== v_exp[0]) begin
                    n_errors++;
                    $display("FAIL backpressure_hold: got ready=%0b valid=%0b instr=%08h, expected 0 1 %08h",
                             m_if.in_ready, m_if.out_valid, m_if.out_instr, v_exp[0]);
                end
                m_if.out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int popped_before = n_popped;
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send((i * 5) % NV);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_if.out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                m_if.out_ready = 1'b1;
            end
        join
        wait_drain();
        n_checks++;
        if (n_popped - popped_before != 16) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d outputs, expected 16", n_popped - popped_before);
        end
    endtask

    task automatic test_mid_reset();
        m_if.out_ready = 1'b0;
        send(4);
        send(1);
        n_checks++;
        if (m_if.in_ready !== 1'b0 || m_if.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL full_before_reset: got ready=%0b valid=%0b, expected 0 1", m_if.in_ready, m_if.out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 8'd0;
        @(negedge clk);
        n_checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1 || m_if.err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL mid_reset: got valid=%0b ready=%0b cnt=%0d, expected 0 1 0",
                     m_if.out_valid, m_if.in_ready, m_if.err_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_s;
        s_if.out_ready = 1'b1;
        s_if.in_valid  = 1'b1;
        s_if.in_instr  = 32'h00000013;
        s_if.in_imm    = 32'h00000000;
        s_if.in_sel    = 3'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            exp_s = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_checks++;
            if (s_if.err_count !== exp_s || s_if.out_err !== 1'b1) begin
                n_errors++;
                $display("FAIL saturation: step %0d got cnt=%0d err=%0b, expected cnt=%0d err=1",
                         i, s_if.err_count, s_if.out_err, exp_s);
            end
        end
        s_if.in_valid = 1'b0;
    endtask

    initial begin
        m_if.in_valid  = 1'b0;
        m_if.in_instr  = 32'd0;
        m_if.in_imm    = 32'd0;
        m_if.in_sel    = 3'd0;
        m_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b0;
        s_if.in_instr  = 32'd0;
        s_if.in_imm    = 32'd0;
        s_if.in_sel    = 3'd0;
        s_if.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_encode();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_saturation();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
